serial_compare_ctrl: RTL and testbench
======================================

Name: serial_compare_ctrl

Overview:
- Controller and arbiter for the bit-serial magnitude comparator datapath.
- Accepts parallel unsigned operand pairs from two requesters and arbitrates between them round-robin.
- Feeds the granted pair MSB-first, one bit per clock, into an internal serial compare core (lt/gt/eq flag registers), optionally terminating early.
- Returns lt/gt/eq plus the requester ID over a valid/ready result port.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- EARLY_EXIT, 1, 1 = finish as soon as the result is decided; 0 = always shift all WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_ready  out  1  requester 1 pair accepted this cycle.
- req1_a  in  WIDTH  requester 1 operand A.
- req1_b  in  WIDTH  requester 1 operand B.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_lt  out  1  A < B.
- res_gt  out  1  A > B.
- res_eq  out  1  A == B.
- res_id  out  1  requester that owns the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_n low, asynchronous, any state, including mid-SHIFT or mid-DONE):
  - state = IDLE; res_valid = 0; res_lt = 0; res_gt = 0; res_eq = 1; res_id = 0; busy = 0.
  - Shift registers and bit counter cleared; round-robin pointer last_id = 1, so req0 wins the first tie.
  - Any in-flight compare is discarded with no result. Both ready outputs are low while reset is asserted.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Grant is combinational: the single valid requester, or if both are valid, the requester != last_id.
  - req*_ready = (state == IDLE) & grant for that requester; the non-granted ready stays 0 and that requester must hold valid and data.
  - On handshake:
    - Capture a/b into shift registers.
    - Set lt = 0, gt = 0, eq = 1.
    - Set cnt = WIDTH-1.
    - Latch res_id and last_id = granted ID.
    - Next state = SHIFT.
  - No valid requester: remain in IDLE.
- SHIFT (one bit per cycle; cycle i examines operand bit WIDTH-1-i):
  - Let a_msb and b_msb be the current shift-register MSBs.
  - If eq and a_msb & ~b_msb: gt = 1, eq = 0.
  - If eq and ~a_msb & b_msb: lt = 1, eq = 0.
  - Once decided, flags are sticky.
  - Both shift registers shift left by 1; cnt decrements.
  - Go to DONE when cnt == 0, or when EARLY_EXIT = 1 and the flags are decided this cycle.
  - cnt never wraps below 0.
- DONE:
  - res_valid = 1; res_lt, res_gt and res_eq hold the final flags and are exactly one-hot.
  - Outputs stay stable while res_ready = 0.
  - On res_valid & res_ready, go to IDLE. The result is held only until handshake; no new grant is made in the DONE cycle.
- Latency:
  - Request handshake at cycle t. With EARLY_EXIT = 1 and the first differing bit at MSB-index k, res_valid rises at t+k+2.
  - Equal operands, or EARLY_EXIT = 0: res_valid rises at t+WIDTH+1.
  - Back-to-back throughput: the next grant is no earlier than the cycle after the result handshake.
- Valid/ready inputs are sampled only in IDLE. A requester dropping valid before its grant is legal; nothing is latched.

Test Plan:
- WIDTH=8, EARLY_EXIT=1: req0 a=0x5A, b=0x5A -> req0_ready at t; res_valid at t+9 with eq=1, lt=0, gt=0, id=0.
- req1 a=0x80, b=0x7F -> gt=1 at t+2 (k=0); with EARLY_EXIT=0 the same pair gives gt=1 at t+9.
- Both requesters valid continuously: req0 a=0x01, b=0x02 and req1 a=0xF0, b=0x0F -> grants alternate 0, 1, 0, 1; first result id=0 lt=1, second id=1 gt=1; the non-granted ready is never high.
- res_ready held 0 for 5 cycles after res_valid -> flags and id stable, busy=1, no new ready issued; handshake -> IDLE next cycle.
- reset_n pulsed low during SHIFT (cycle 3 of 8) -> immediate res_valid=0, eq=1, busy=0; after release a tied request goes to req0.
- a=0x00, b=0xFF -> lt=1 at t+2; a=0xFE, b=0xFF (k=7) -> lt=1 at t+9.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// Two-requester round-robin front end for a bit-serial MSB-first magnitude
// comparator; returns lt/gt/eq plus the owning requester over valid/ready.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_lt,
  output logic             res_gt,
  output logic             res_eq,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_a_nxt;
  logic [WIDTH-1:0] sh_b, sh_b_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             lt, lt_nxt;
  logic             gt, gt_nxt;
  logic             eq, eq_nxt;
  logic             id_q, id_nxt;
  logic             last_id, last_id_nxt;

  logic             grant0, grant1;
  logic             take, take_id;
  logic             hit_gt, hit_lt;

  // Grant only in IDLE and never while reset is held; a tie goes to the
  // requester that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_id;
        grant1 = ~last_id;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign take    = grant0 | grant1;
  assign take_id = grant1;

  assign hit_gt = eq &  sh_a[WIDTH-1] & ~sh_b[WIDTH-1];
  assign hit_lt = eq & ~sh_a[WIDTH-1] &  sh_b[WIDTH-1];

  always_comb begin
    state_nxt   = state;
    sh_a_nxt    = sh_a;
    sh_b_nxt    = sh_b;
    cnt_nxt     = cnt;
    lt_nxt      = lt;
    gt_nxt      = gt;
    eq_nxt      = eq;
    id_nxt      = id_q;
    last_id_nxt = last_id;
    case (state)
      IDLE: begin
        if (take) begin
          sh_a_nxt    = take_id ? req1_a : req0_a;
          sh_b_nxt    = take_id ? req1_b : req0_b;
          lt_nxt      = 1'b0;
          gt_nxt      = 1'b0;
          eq_nxt      = 1'b1;
          cnt_nxt     = CW'(WIDTH - 1);
          id_nxt      = take_id;
          last_id_nxt = take_id;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (hit_gt) begin
          gt_nxt = 1'b1;
          eq_nxt = 1'b0;
        end
        if (hit_lt) begin
          lt_nxt = 1'b1;
          eq_nxt = 1'b0;
        end
        sh_a_nxt = {sh_a[WIDTH-2:0], 1'b0};
        sh_b_nxt = {sh_b[WIDTH-2:0], 1'b0};
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end
        if (cnt == '0 || (EARLY_EXIT && (hit_gt || hit_lt))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      lt      <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b1;
      id_q    <= 1'b0;
      last_id <= 1'b1;
    end else begin
      state   <= state_nxt;
      sh_a    <= sh_a_nxt;
      sh_b    <= sh_b_nxt;
      cnt     <= cnt_nxt;
      lt      <= lt_nxt;
      gt      <= gt_nxt;
      eq      <= eq_nxt;
      id_q    <= id_nxt;
      last_id <= last_id_nxt;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == DONE);
  assign res_lt     = lt;
  assign res_gt     = gt;
  assign res_eq     = eq;
  assign res_id     = id_q;
  assign busy       = (state != IDLE);

  a_onehot_done: assert property (@(posedge clk) disable iff (!reset_n)
    (state == DONE) |-> $onehot({lt, gt, eq}));

  a_single_grant: assert property (@(posedge clk) disable iff (!reset_n)
    !(grant0 && grant1));

  a_hold_result: assert property (@(posedge clk) disable iff (!reset_n)
    (state == DONE && !res_ready) |=> (state == DONE && $stable({lt, gt, eq, id_q})));

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Randomized bench for serial_compare_ctrl: one instance with early exit,
// one without, both checked against an arithmetic reference model.
module tb_serial_compare_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset_n;

  logic [1:0]        r0v, r1v, rr;
  logic [1:0][W-1:0] a0, b0, a1, b1;
  logic [1:0]        r0r, r1r, rv, lt, gt, eq, id, bsy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit   [1:0]  model_last;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0v[0]), .req0_ready(r0r[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(r1v[0]), .req1_ready(r1r[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .res_valid(rv[0]), .res_ready(rr[0]),
    .res_lt(lt[0]), .res_gt(gt[0]), .res_eq(eq[0]), .res_id(id[0]),
    .busy(bsy[0])
  );

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0v[1]), .req0_ready(r0r[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(r1v[1]), .req1_ready(r1r[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .res_valid(rv[1]), .res_ready(rr[1]),
    .res_lt(lt[1]), .res_gt(gt[1]), .res_eq(eq[1]), .res_id(id[1]),
    .busy(bsy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference latency in cycles from request handshake to res_valid.
  function automatic int unsigned ref_latency(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input bit early);
    int unsigned lat;
    lat = W + 1;
    if (early) begin
      for (int i = 0; i < W; i++) begin
        if (a[i] != b[i]) lat = (W - 1 - i) + 2;
      end
    end
    return lat;
  endfunction

  // Entered and left just after a rising edge.
  task automatic run_txn(input int unsigned u, input bit v0, input bit v1,
                         input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                         input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                         input int unsigned hold);
    int unsigned gid, lat, want_lat;
    logic [W-1:0] ea, eb;
    logic s_lt, s_gt, s_eq, s_id;
    bit got;
    r0v[u] = v0; r1v[u] = v1;
    a0[u] = xa0; b0[u] = xb0; a1[u] = xa1; b1[u] = xb1;
    @(negedge clk);
    if (!v0 && !v1) begin
      check("idle_ready", {r1r[u], r0r[u]}, 2'b00);
      check("idle_busy", bsy[u], 1'b0);
      @(posedge clk); #1;
      return;
    end
    gid = (v0 && v1) ? (model_last[u] ? 0 : 1) : (v1 ? 1 : 0);
    check("grant", {r1r[u], r0r[u]}, (gid == 1) ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    model_last[u] = gid[0];
    r0v[u] = 1'b1; r1v[u] = 1'b1;
    ea = (gid == 1) ? xa1 : xa0;
    eb = (gid == 1) ? xb1 : xb0;
    want_lat = ref_latency(ea, eb, (u == 0));
    lat = 1;
    @(negedge clk);
    got = rv[u];
    while (!got && lat < 40) begin
      check("busy_ready", {bsy[u], r1r[u], r0r[u]}, 3'b100);
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = rv[u];
    end
    check("res_valid", got, 1'b1);
    check("latency", lat, want_lat);
    check("res_lt", lt[u], ea < eb);
    check("res_gt", gt[u], ea > eb);
    check("res_eq", eq[u], ea == eb);
    check("res_id", id[u], gid[0]);
    check("done_busy", bsy[u], 1'b1);
    s_lt = ea < eb; s_gt = ea > eb; s_eq = ea == eb; s_id = gid[0];
    for (int unsigned c = 0; c < hold; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out", {rv[u], lt[u], gt[u], eq[u], id[u], bsy[u]},
            {1'b1, s_lt, s_gt, s_eq, s_id, 1'b1});
      check("hold_ready", {r1r[u], r0r[u]}, 2'b00);
    end
    rr[u] = 1'b1;
    @(posedge clk); #1;
    rr[u] = 1'b0; r0v[u] = 1'b0; r1v[u] = 1'b0;
    @(negedge clk);
    check("post_idle", {rv[u], bsy[u]}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic rand_txn(input int unsigned u);
    logic [W-1:0] x0, y0, x1, y1;
    int unsigned sel;
    x0 = W'($urandom); x1 = W'($urandom);
    sel = $urandom_range(0, 2);
    y0 = (sel == 0) ? W'($urandom) : (sel == 1) ? x0 : (x0 ^ W'(1 << $urandom_range(0, W - 1)));
    sel = $urandom_range(0, 2);
    y1 = (sel == 0) ? W'($urandom) : (sel == 1) ? x1 : (x1 ^ W'(1 << $urandom_range(0, W - 1)));
    sel = $urandom_range(0, 3);
    run_txn(u, sel[0], sel[1], x0, y0, x1, y1, $urandom_range(0, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    r0v = '0; r1v = '0; rr = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_last = 2'b11;
    repeat (2) @(posedge clk);
    #1 r0v = 2'b11; r1v = 2'b11;
    @(negedge clk);
    for (int unsigned u = 0; u < 2; u++) begin
      check("reset_out", {rv[u], lt[u], gt[u], eq[u], id[u], bsy[u]}, 6'b000100);
      check("reset_ready", {r1r[u], r0r[u]}, 2'b00);
    end
    r0v = '0; r1v = '0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_txn(0, 1'b1, 1'b0, 8'h5A, 8'h5A, 8'h00, 8'h00, 0);
    run_txn(0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h7F, 0);
    run_txn(1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h7F, 0);
    for (int i = 0; i < 4; i++) run_txn(0, 1'b1, 1'b1, 8'h01, 8'h02, 8'hF0, 8'h0F, 0);
    run_txn(0, 1'b1, 1'b0, 8'h33, 8'h3C, 8'h00, 8'h00, 5);
    run_txn(0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    run_txn(0, 1'b1, 1'b0, 8'hFE, 8'hFF, 8'h00, 8'h00, 0);
    run_txn(1, 1'b1, 1'b1, 8'hFE, 8'hFF, 8'h00, 8'hFF, 1);

    for (int unsigned u = 0; u < 2; u++) begin
      repeat (40) rand_txn(u);
    end

    // Reset during the third shift cycle: nothing may surface afterwards.
    r0v[0] = 1'b1; a0[0] = 8'h5A; b0[0] = 8'h5A;
    @(negedge clk);
    check("rst_pre_grant", r0r[0], 1'b1);
    @(posedge clk); #1;
    r0v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_pre_busy", bsy[0], 1'b1);
    reset_n = 1'b0;
    r0v = 2'b11; r1v = 2'b11;
    #1;
    check("rst_mid_out", {rv[0], lt[0], gt[0], eq[0], id[0], bsy[0]}, 6'b000100);
    check("rst_mid_ready", {r1r[0], r0r[0], r1r[1], r0r[1]}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    model_last = 2'b11;
    r0v = '0; r1v = '0;
    @(posedge clk); #1;
    run_txn(0, 1'b1, 1'b1, 8'h10, 8'h20, 8'h20, 8'h10, 0);
    run_txn(0, 1'b1, 1'b1, 8'h10, 8'h20, 8'h20, 8'h10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
